// File: rtl/thread_lsu.sv
// thread_lsu: per-thread load/store unit that turns LDR/STR into memory valid/ready transactions
module thread_lsu #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           core_state,
    input  logic                 decoded_mem_read_enable,
    input  logic                 decoded_mem_write_enable,
    input  logic [7:0]           rs,
    input  logic [DATA_BITS-1:0] rt,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out
);
    typedef enum logic [1:0] {IDLE = 2'b00, REQUESTING = 2'b01, WAITING = 2'b10, DONE = 2'b11} state_t;
    localparam logic [2:0] REQUEST = 3'b011;
    localparam logic [2:0] UPDATE  = 3'b110;
    state_t state;
    assign lsu_state = state;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
        end else if (enable) begin
            case (state)
                IDLE: if (core_state == REQUEST && (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                    state <= REQUESTING;
                    // a read wins when both enables are set; the write is dropped
                    if (decoded_mem_read_enable) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= rs[ADDR_BITS-1:0];
                    end else begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= rs[ADDR_BITS-1:0];
                        mem_write_data    <= rt;
                    end
                end
                REQUESTING, WAITING: begin
                    if (mem_read_valid && mem_read_ready) begin
                        lsu_out        <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        state          <= DONE;
                    end else if (mem_write_valid && mem_write_ready) begin
                        mem_write_valid <= 1'b0;
                        state           <= DONE;
                    end else begin
                        state <= WAITING;
                    end
                end
                DONE: if (core_state == UPDATE) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_thread_lsu.sv
// tb_thread_lsu: directed stimulus against a transaction-level model of thread_lsu
module tb_thread_lsu;
    logic       clk = 0, reset = 1, enable = 1;
    logic [2:0] core_state = 0;
    logic       re = 0, we = 0;
    logic [7:0] rs = 0, rt = 0;
    logic       rv, wv, rready = 0, wready = 0;
    logic [7:0] raddr, waddr, wdata, rdata = 0, lsu_out;
    logic [1:0] lsu_state;
    int checks = 0, errors = 0;
    bit go = 0;

    thread_lsu dut (
        .clk(clk), .reset(reset), .enable(enable), .core_state(core_state),
        .decoded_mem_read_enable(re), .decoded_mem_write_enable(we),
        .rs(rs), .rt(rt),
        .mem_read_valid(rv), .mem_read_address(raddr), .mem_read_ready(rready), .mem_read_data(rdata),
        .mem_write_valid(wv), .mem_write_address(waddr), .mem_write_data(wdata), .mem_write_ready(wready),
        .lsu_state(lsu_state), .lsu_out(lsu_out)
    );

    always #5 clk = ~clk;

    // model: pending op kind (0 none, 1 read, 2 write), cycles it has been outstanding, done flag
    int       m_kind, m_age;
    bit       m_done;
    logic [7:0] m_raddr, m_waddr, m_wdata, m_out;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_kind = 0; m_age = 0; m_done = 0;
            m_raddr = 0; m_waddr = 0; m_wdata = 0; m_out = 0;
        end else if (enable) begin
            if (m_done) begin
                if (core_state == 3'd6) m_done = 0;
            end else if (m_kind == 0) begin
                if (core_state == 3'd3 && (re || we)) begin
                    m_age = 0;
                    if (re) begin m_kind = 1; m_raddr = rs; end
                    else begin m_kind = 2; m_waddr = rs; m_wdata = rt; end
                end
            end else if ((m_kind == 1 && rready) || (m_kind == 2 && wready)) begin
                if (m_kind == 1) m_out = rdata;
                m_kind = 0;
                m_done = 1;
            end else begin
                m_age++;
            end
        end
    end

    function automatic logic [1:0] m_state();
        return m_done ? 2'd3 : (m_kind == 0 ? 2'd0 : (m_age == 0 ? 2'd1 : 2'd2));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (go) begin
            chk("rv", rv, m_kind == 1);
            chk("wv", wv, m_kind == 2);
            chk("raddr", raddr, m_raddr);
            chk("waddr", waddr, m_waddr);
            chk("wdata", wdata, m_wdata);
            chk("state", lsu_state, m_state());
            chk("out", lsu_out, m_out);
            chk("onehot", rv && wv, 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic issue(input logic r, input logic w, input logic [7:0] a, input logic [7:0] d);
        core_state = 3'd3; re = r; we = w; rs = a; rt = d;
        cyc(1);
        core_state = 3'd4; re = 0; we = 0; rs = 8'hFF; rt = 8'hEE;
    endtask

    initial begin
        cyc(2);
        go = 1;
        chk("rst_state", lsu_state, 0);
        chk("rst_out", lsu_out, 0);
        reset = 0;
        cyc(1);
        // load with ready on edge 4
        issue(1, 0, 8'h2A, 8'h00);
        chk("ld_rv", rv, 1); chk("ld_addr", raddr, 8'h2A); chk("ld_s1", lsu_state, 1);
        cyc(1);
        chk("ld_s2", lsu_state, 2);
        cyc(1);
        chk("ld_s3", lsu_state, 2);
        rready = 1; rdata = 8'h5C;
        cyc(1);
        rready = 0; rdata = 0;
        chk("ld_out", lsu_out, 8'h5C); chk("ld_rv0", rv, 0); chk("ld_done", lsu_state, 3);
        core_state = 3'd6;
        cyc(1);
        chk("ld_idle", lsu_state, 0);
        core_state = 3'd0;
        cyc(1);
        // store with immediate ready
        issue(0, 1, 8'h10, 8'h77);
        chk("st_wv", wv, 1); chk("st_addr", waddr, 8'h10); chk("st_data", wdata, 8'h77);
        wready = 1;
        rready = 1; rdata = 8'hAB;
        cyc(1);
        wready = 0; rready = 0;
        chk("st_wv0", wv, 0); chk("st_done", lsu_state, 3); chk("st_out", lsu_out, 8'h5C);
        core_state = 3'd6; cyc(1); core_state = 3'd0; cyc(1);
        // both enables: read wins, stray write ready ignored
        issue(1, 1, 8'h03, 8'hAA);
        chk("both_rv", rv, 1); chk("both_wv", wv, 0); chk("both_addr", raddr, 8'h03);
        wready = 1;
        cyc(1);
        chk("both_wait", lsu_state, 2);
        wready = 0; rready = 1; rdata = 8'h31;
        cyc(1);
        rready = 0;
        chk("both_out", lsu_out, 8'h31); chk("both_done", lsu_state, 3);
        core_state = 3'd6; cyc(1); core_state = 3'd0; cyc(1);
        // disabled while waiting
        issue(1, 0, 8'h44, 8'h00);
        cyc(1);
        enable = 0; rready = 1; rdata = 8'h11;
        cyc(2);
        chk("dis_state", lsu_state, 2); chk("dis_rv", rv, 1); chk("dis_out", lsu_out, 8'h31);
        enable = 1; rdata = 8'h99;
        cyc(1);
        rready = 0;
        chk("en_out", lsu_out, 8'h99); chk("en_done", lsu_state, 3);
        core_state = 3'd6; cyc(1); core_state = 3'd0; cyc(1);
        // async reset while waiting
        issue(1, 0, 8'h55, 8'h00);
        cyc(1);
        #2 reset = 1;
        #1;
        chk("ar_rv", rv, 0); chk("ar_state", lsu_state, 0); chk("ar_out", lsu_out, 0); chk("ar_addr", raddr, 0);
        cyc(1);
        reset = 0; rready = 1; rdata = 8'h66;
        cyc(1);
        rready = 0;
        chk("ar_ign_state", lsu_state, 0); chk("ar_ign_out", lsu_out, 0);
        // DONE persistence and no re-entry before UPDATE
        issue(1, 0, 8'h66, 8'h00);
        rready = 1; rdata = 8'h42;
        cyc(1);
        rready = 0;
        cyc(5);
        chk("dn_state", lsu_state, 3); chk("dn_out", lsu_out, 8'h42);
        core_state = 3'd3; re = 1; rs = 8'h77;
        cyc(1);
        chk("dn_norq", rv, 0); chk("dn_hold", lsu_state, 3);
        core_state = 3'd6; re = 0;
        cyc(1);
        chk("dn_idle", lsu_state, 0);
        issue(1, 0, 8'h77, 8'h00);
        chk("dn_rq", rv, 1); chk("dn_addr", raddr, 8'h77);
        rready = 1; rdata = 8'hC3;
        cyc(1);
        rready = 0;
        chk("dn_out2", lsu_out, 8'hC3);
        cyc(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/thread_lsu.md
Name: thread_lsu

Overview:
- Per-thread load/store unit for the SIMD core.
- Takes the rs/rt operands from the thread's register file and turns LDR/STR instructions into valid/ready transactions toward the memory controller.
- Returns loaded data on lsu_out, which the register file writes back in UPDATE.
- Reports its progress on lsu_state so the scheduler can hold the core in WAIT until every thread's LSU reaches DONE.

Parameters:
- ADDR_BITS, 8, width of memory address (taken from rs[ADDR_BITS-1:0]).
- DATA_BITS, 8, width of memory data word, lsu_out and rt.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  thread active in current block; low means hold all state.
- core_state  input  3  core phase: IDLE 000, FETCH 001, DECODE 010, REQUEST 011, WAIT 100, EXECUTE 101, UPDATE 110, DONE 111.
- decoded_mem_read_enable  input  1  current instruction is LDR.
- decoded_mem_write_enable  input  1  current instruction is STR.
- rs  input  8  address operand.
- rt  input  DATA_BITS  store data operand.
- mem_read_valid  output  1  read request pending.
- mem_read_address  output  ADDR_BITS  read address.
- mem_read_ready  input  1  read accepted and data returned.
- mem_read_data  input  DATA_BITS  read data, valid when mem_read_ready=1.
- mem_write_valid  output  1  write request pending.
- mem_write_address  output  ADDR_BITS  write address.
- mem_write_data  output  DATA_BITS  write data.
- mem_write_ready  input  1  write accepted.
- lsu_state  output  2  IDLE 00, REQUESTING 01, WAITING 10, DONE 11.
- lsu_out  output  DATA_BITS  last loaded value.

Behaviour:
- Reset: asynchronous; all outputs go to 0 immediately, including both valids, addresses, write data, lsu_out and lsu_state (IDLE).
  - Reset mid-transaction drops valid without waiting for ready.
  - A ready arriving after reset deasserts is ignored.
- enable=0: no state change; all outputs hold their values, including an asserted valid.
- IDLE: leaves IDLE only when core_state=REQUEST and read or write enable is set.
  - On that edge: lsu_state<=REQUESTING.
  - For a read: mem_read_valid<=1 and mem_read_address<=rs[ADDR_BITS-1:0].
  - For a write: mem_write_valid<=1, mem_write_address<=rs and mem_write_data<=rt.
  - Address and data are latched at this edge; later changes on rs/rt have no effect.
  - Both enables set: the read is performed and the write is dropped.
  - Neither enable set: stay in IDLE.
- REQUESTING: valid held.
  - If the matching ready=1 this cycle: complete (see below).
  - Otherwise go to WAITING next edge.
- WAITING: valid held until the matching ready=1, with no timeout.
- Completion:
  - Read: on the edge where mem_read_ready=1, lsu_out<=mem_read_data and mem_read_valid<=0.
  - Write: on the edge where mem_write_ready=1, mem_write_valid<=0; lsu_out is unchanged.
  - In both cases lsu_state<=DONE.
  - Minimum latency from the REQUEST edge to DONE is 2 edges.
- Non-matching handshake inputs are ignored in every state: write ready during a read, read ready during a write, or any ready while in IDLE or DONE.
- DONE: holds until core_state=UPDATE, then returns to IDLE on that edge.
  - lsu_out stays stable through UPDATE so the register file captures it.
  - A new REQUEST is accepted only from IDLE.
- Address/data outputs keep their last values after valid drops. They are don't-care to the controller but must be deterministic.
- At most one of mem_read_valid or mem_write_valid is high at any time.
- lsu_out changes only on read completion or reset.

Test Plan:
- Load, ready after 3 cycles: core_state=REQUEST, read_en=1, rs=0x2A.
  - Expect read_valid=1 and addr=0x2A from edge 1, state 01 then 10.
  - Ready with data 0x5C at edge 4 -> lsu_out=0x5C, valid=0, state 11.
  - core_state=UPDATE -> state 00.
- Store, immediate ready: write_en=1, rs=0x10, rt=0x77, mem_write_ready=1 during REQUESTING.
  - Expect write_valid/addr/data = 1/0x10/0x77 for exactly one cycle.
  - DONE at edge 2; lsu_out unchanged (prior 0x5C).
- Both enables, rs=0x03: only mem_read_valid rises, mem_write_valid stays 0 throughout, and the load completes normally.
- enable=0 mid-WAITING with valid=1: pulse mem_read_ready=1 while disabled -> ignored, state and valid held.
  - Re-enable, then ready with data 0x99 -> lsu_out=0x99.
- Async reset in WAITING between clock edges: valid, lsu_state and lsu_out drop to 0 before the next edge.
  - A subsequent ready pulse has no effect.
- DONE persistence: hold core_state=WAIT for 5 cycles -> state stays 11 and lsu_out stable.
  - A REQUEST with read_en while in DONE is not accepted until after UPDATE.
